// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order and the active-high glyph patterns.
// Bit order of every 7-bit segment vector: bit6=a, bit5=b, ... bit0=g.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_bcd_decoder.sv
// Combinational BCD nibble to active-high segment pattern; codes 10-15 render a dash.
module seg7_bcd_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display_driver.sv
// Multiplexed NUM_DIGITS 7-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_display_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic                      load_ack,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] sh_bcd_q, sh_bcd_d, act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    ack_q, ack_d;
    logic                    frame_q, frame_d;

    logic                    tick, wrap;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic                    cur_dark;
    logic [NUM_DIGITS-1:0]   dig_hot;
    logic [NUM_DIGITS-1:0]   lz_blank;

    // A load in the wrap cycle flows through the shadow into active, leaving pending clear.
    always_comb begin
        tick        = (cnt_q == CNT_LAST);
        wrap        = tick && (idx_q == IDX_LAST);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        sh_bcd_d    = load ? bcd_in : sh_bcd_q;
        sh_blank_d  = load ? blank_in : sh_blank_q;
        pend_d      = pend_q | load;
        act_bcd_d   = act_bcd_q;
        act_blank_d = act_blank_q;
        if (wrap && pend_d) begin
            act_bcd_d   = sh_bcd_d;
            act_blank_d = sh_blank_d;
            pend_d      = 1'b0;
        end
        ack_d       = load;
        frame_d     = wrap;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lz_seen;

    always_comb begin
        lz_seen  = 1'b0;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (act_bcd_d[4*i +: 4] != 4'd0) begin
                lz_seen = 1'b1;
            end
            lz_blank[i] = ~lz_seen;
        end
    end
`else
    assign lz_blank = '0;
`endif

    seg7_bcd_decoder u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

    // Output registers load the glyph for the index being entered, so they track the slot exactly.
    always_comb begin
        cur_nib  = act_bcd_d[4*idx_d +: 4];
        cur_dark = act_blank_d[idx_d] | lz_blank[idx_d];
        dig_hot  = '0;
        dig_hot[idx_d] = 1'b1;
        seg_d    = seg_q;
        dig_d    = dig_q;
        if (tick) begin
            seg_d = (cur_dark ? SEG_OFF : dec_seg) ^ SEG_INV;
            dig_d = dig_hot ^ DIG_INV;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            sh_bcd_q    <= '0;
            sh_blank_q  <= '1;
            act_bcd_q   <= '0;
            act_blank_q <= '1;
            seg_q       <= SEG_OFF ^ SEG_INV;
            dig_q       <= DIG_INV;
            ack_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            sh_bcd_q    <= sh_bcd_d;
            sh_blank_q  <= sh_blank_d;
            act_bcd_q   <= act_bcd_d;
            act_blank_q <= act_blank_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
        end
    end

    assign load_ack   = ack_q;
    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_display_driver.sv
// Bench for seg7_scan_display_driver (4 digits, divide-by-4 slots, common-anode polarity).
module tb_seg7_scan_display_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  blank_in;
    logic        load_ack;
    logic [6:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    logic [12:0] exp_q[$];
    logic [12:0] exp_v;
    int          n_vec;
    int          n_err;

    // Reference model state
    int          m_cnt, m_idx;
    logic        m_pend, m_ack, m_fd;
    logic [15:0] m_sh_bcd, m_act_bcd;
    logic [3:0]  m_sh_blank, m_act_blank;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;

    seg7_scan_display_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .blank_in   (blank_in),
        .load_ack   (load_ack),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Active-low glyphs, bit6=a .. bit0=g.
    function automatic logic [6:0] al_glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic logic digit_dark(input logic [15:0] v, input logic [3:0] bl, input int d);
        logic dark;
        dark = bl[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0) begin
            logic nz_above;
            nz_above = 1'b0;
            for (int k = d; k < 4; k++) begin
                if (v[4*k +: 4] != 4'd0) nz_above = 1'b1;
            end
            if (!nz_above) dark = 1'b1;
        end
`endif
        return dark;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 1'b0; m_ack = 1'b0; m_fd = 1'b0;
        m_sh_bcd = 16'h0; m_act_bcd = 16'h0;
        m_sh_blank = 4'hF; m_act_blank = 4'hF;
        m_seg = 7'h7F; m_dig = 4'hF;
    endtask

    task automatic model_step(input logic ld, input logic [15:0] b, input logic [3:0] bl);
        logic tick, wrap;
        tick = (m_cnt == 3);
        wrap = tick && (m_idx == 3);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (tick) m_idx = (m_idx == 3) ? 0 : m_idx + 1;
        if (ld) begin
            m_sh_bcd = b; m_sh_blank = bl; m_pend = 1'b1;
        end
        if (wrap && m_pend) begin
            m_act_bcd = m_sh_bcd; m_act_blank = m_sh_blank; m_pend = 1'b0;
        end
        m_ack = ld;
        m_fd  = wrap;
        if (tick) begin
            m_seg = digit_dark(m_act_bcd, m_act_blank, m_idx) ? 7'h7F : al_glyph(m_act_bcd[4*m_idx +: 4]);
            m_dig = ~(4'b0001 << m_idx);
        end
    endtask

    // One clock of stimulus; pushes the model's expectation for the resulting outputs.
    task automatic drive(input logic ld, input logic [15:0] b, input logic [3:0] bl);
        load = ld; bcd_in = b; blank_in = bl;
        @(posedge clk);
        model_step(ld, b, bl);
        exp_q.push_back({m_ack, m_fd, m_dig, m_seg});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; bcd_in = '0; blank_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({load_ack, frame_done, dig_sel, seg_out} !== 13'b0_0_1111_1111111) begin
            n_err++;
            $display("FAIL reset_state: got %b exp %b", {load_ack, frame_done, dig_sel, seg_out}, 13'b0_0_1111_1111111);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        int fd_cnt;
        fd_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
                n_err++;
                $display("FAIL idle_scan c=%0d: got %b exp %b", c, {load_ack, frame_done, dig_sel, seg_out}, exp_v);
            end
            if (frame_done) fd_cnt++;
        end
        n_vec++;
        if (fd_cnt !== 2) begin
            n_err++;
            $display("FAIL idle_frame_count: got %0d exp 2", fd_cnt);
        end
    endtask

    task automatic test_load_commit();
        logic [6:0] rec[4];
        logic       fd_seen;
        logic       early_lit;
        fd_seen = 1'b0; early_lit = 1'b0;
        for (int d = 0; d < 4; d++) rec[d] = 7'hxx;
        drive(1'b1, 16'h1234, 4'b0000);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (load_ack !== 1'b1 || {load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
            n_err++;
            $display("FAIL load_ack: got %b exp %b", {load_ack, frame_done, dig_sel, seg_out}, exp_v);
        end
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
                n_err++;
                $display("FAIL load_commit c=%0d: got %b exp %b", c, {load_ack, frame_done, dig_sel, seg_out}, exp_v);
            end
            if (frame_done) fd_seen = 1'b1;
            if (!fd_seen && seg_out !== 7'h7F) early_lit = 1'b1;
            for (int d = 0; d < 4; d++) if (fd_seen && dig_sel == ~(4'b0001 << d)) rec[d] = seg_out;
        end
        n_vec++;
        if (early_lit !== 1'b0) begin
            n_err++;
            $display("FAIL no_tearing: got %b exp 0", early_lit);
        end
        n_vec++;
        if (rec[0] !== 7'b1001100 || rec[3] !== 7'b1001111) begin
            n_err++;
            $display("FAIL commit_1234: got d0=%b d3=%b exp d0=1001100 d3=1001111", rec[0], rec[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] rec[4];
        logic       dash_seen;
        int         guard;
        dash_seen = 1'b0; guard = 0;
        for (int d = 0; d < 4; d++) rec[d] = 7'hxx;
        while (!(m_idx == 1 && m_cnt == 0) && guard < 32) begin
            drive(1'b0, 16'h0, 4'h0);
            void'(exp_q.pop_front());
            guard++;
        end
        n_vec++;
        if (guard >= 32) begin
            n_err++;
            $display("FAIL b2b_align: got %0d exp <32", guard);
        end
        drive(1'b1, 16'h00A7, 4'b0000);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (load_ack !== 1'b1 || {load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
            n_err++;
            $display("FAIL b2b_ack1: got %b exp %b", {load_ack, frame_done, dig_sel, seg_out}, exp_v);
        end
        drive(1'b1, 16'h5678, 4'b0000);
        exp_v = exp_q.pop_front();
        n_vec++;
        if (load_ack !== 1'b1 || {load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
            n_err++;
            $display("FAIL b2b_ack2: got %b exp %b", {load_ack, frame_done, dig_sel, seg_out}, exp_v);
        end
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
                n_err++;
                $display("FAIL b2b_scan c=%0d: got %b exp %b", c, {load_ack, frame_done, dig_sel, seg_out}, exp_v);
            end
            if (seg_out === 7'b1111110) dash_seen = 1'b1;
            for (int d = 0; d < 4; d++) if (dig_sel == ~(4'b0001 << d)) rec[d] = seg_out;
        end
        n_vec++;
        if (dash_seen !== 1'b0 || rec[0] !== 7'b0000000 || rec[3] !== 7'b0100100) begin
            n_err++;
            $display("FAIL b2b_last_wins: got dash=%b d0=%b d3=%b exp dash=0 d0=0000000 d3=0100100", dash_seen, rec[0], rec[3]);
        end
    endtask

    task automatic test_load_on_wrap();
        int guard;
        guard = 0;
        while (!(m_idx == 3 && m_cnt == 3) && guard < 32) begin
            drive(1'b0, 16'h0, 4'h0);
            void'(exp_q.pop_front());
            guard++;
        end
        n_vec++;
        if (guard >= 32) begin
            n_err++;
            $display("FAIL wrap_align: got %0d exp <32", guard);
        end
        drive(1'b1, 16'h9999, 4'b0000);
        exp_v = exp_q.pop_front();
        n_vec++;
        if ({load_ack, frame_done, dig_sel, seg_out} !== 13'b1_1_1110_0000100) begin
            n_err++;
            $display("FAIL load_on_wrap: got %b exp %b", {load_ack, frame_done, dig_sel, seg_out}, 13'b1_1_1110_0000100);
        end
        n_vec++;
        if (dut.pend_q !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pending: got %b exp 0", dut.pend_q);
        end
    endtask

    task automatic test_dash_blank();
        logic [6:0] rec[4];
        logic [27:0] want;
        for (int d = 0; d < 4; d++) rec[d] = 7'hxx;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        want = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111110};
`else
        want = {7'b0000001, 7'b1111111, 7'b0000001, 7'b1111110};
`endif
        drive(1'b1, 16'h000C, 4'b0100);
        void'(exp_q.pop_front());
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
                n_err++;
                $display("FAIL dash_blank c=%0d: got %b exp %b", c, {load_ack, frame_done, dig_sel, seg_out}, exp_v);
            end
            if (c >= 20) for (int d = 0; d < 4; d++) if (dig_sel == ~(4'b0001 << d)) rec[d] = seg_out;
        end
        n_vec++;
        if ({rec[3], rec[2], rec[1], rec[0]} !== want) begin
            n_err++;
            $display("FAIL dash_blank_glyphs: got %b exp %b", {rec[3], rec[2], rec[1], rec[0]}, want);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic lit;
        lit = 1'b0;
        while (m_idx == 3) begin
            drive(1'b0, 16'h0, 4'h0);
            void'(exp_q.pop_front());
        end
        drive(1'b1, 16'h4321, 4'b0000);
        void'(exp_q.pop_front());
        n_vec++;
        if (dut.pend_q !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_pending: got %b exp 1", dut.pend_q);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({load_ack, frame_done, dig_sel, seg_out} !== 13'b0_0_1111_1111111) begin
            n_err++;
            $display("FAIL async_reset: got %b exp %b", {load_ack, frame_done, dig_sel, seg_out}, 13'b0_0_1111_1111111);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({load_ack, frame_done, dig_sel, seg_out} !== exp_v) begin
                n_err++;
                $display("FAIL post_reset c=%0d: got %b exp %b", c, {load_ack, frame_done, dig_sel, seg_out}, exp_v);
            end
            if (seg_out !== 7'h7F) lit = 1'b1;
        end
        n_vec++;
        if (lit !== 1'b0 || dut.pend_q !== 1'b0) begin
            n_err++;
            $display("FAIL pending_discarded: got lit=%b pend=%b exp 0/0", lit, dut.pend_q);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_idle_scan();
        test_load_commit();
        test_back_to_back();
        test_load_on_wrap();
        test_dash_blank();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display_driver.md
Name: seg7_scan_display_driver

Overview:
- Parametrised successor to the single-digit BCD-to-7-segment decoders: drives NUM_DIGITS multiplexed 7-segment digits from one shared segment bus.
- Time-multiplexes the digit selects at a divided refresh rate.
- Double-buffers the BCD word so that updates only take effect at frame boundaries, which prevents tearing.
- Sits between the control FSM / score logic and the board's display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
- ACTIVE_LOW, 1, 1 = common-anode board (segments and selects active-low); 0 = active-high.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  single-cycle strobe; captures bcd_in and blank_in
- bcd_in  input  4*NUM_DIGITS  BCD nibbles; nibble 0 (LSBs) = rightmost digit
- blank_in  input  NUM_DIGITS  1 = force that digit dark
- load_ack  output  1  one-cycle pulse, one cycle after load
- seg_out  output  7  segments, bit6=a .. bit0=g, polarity per ACTIVE_LOW
- dig_sel  output  NUM_DIGITS  one-hot digit enable, polarity per ACTIVE_LOW
- frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset values:
  - Prescaler = 0, scan index = 0, pending flag = 0.
  - Active and shadow blank masks = all ones.
  - seg_out and dig_sel = all inactive (all ones if ACTIVE_LOW, else all zeros).
  - load_ack = 0, frame_done = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted for one cycle when the count = REFRESH_DIV-1.
- Scan:
  - On tick, the index advances by 1 and wraps NUM_DIGITS-1 -> 0.
  - frame_done is registered and pulses in the cycle after the tick that wraps the index.
- Load handshake:
  - load=1 writes bcd_in and blank_in to the shadow registers and sets pending.
  - load_ack pulses in the next cycle.
  - Back-to-back loads are each acked; the last write wins.
- Commit:
  - Fires on a wrapping tick (index NUM_DIGITS-1 -> 0) with pending=1.
  - Shadow is copied to active and pending is cleared.
  - If load coincides with a commit tick, the newly loaded value goes straight to active and pending ends at 0.
- Decode:
  - Combinational from the active nibble/mask at the current index.
  - Segment patterns (a..g order): 0-9 standard; 10-15 show a dash (g only).
  - A blanked digit shows all segments off.
- Output timing:
  - seg_out and dig_sel are registered.
  - They reflect the new index one cycle after the tick.
  - Exactly one select is active at any time after the first tick.
- Ghosting:
  - Not handled; both outputs update in the same cycle.
- Polarity:
  - Final inversion is applied at the output register when ACTIVE_LOW=1.
- Reset mid-frame:
  - All state returns to reset values immediately (asynchronous).
  - Pending data is discarded.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits above the most significant non-zero active nibble are additionally blanked.
  - Digit 0 is never auto-blanked.
  - The blank_in mask is ORed in.
- When undefined: zeros display normally.
- Blanking is computed from the active (committed) value only.

Decomposition:
- Shared package / include file seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Bit-order definition.
- Sub-module seg7_bcd_decoder:
  - Pure combinational 4-bit -> 7-bit, active-high.
  - Reusable by the existing single-digit display paths.
- Top module: prescaler, scan counter, shadow/active registers, output registers.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
1. Reset, then idle 40 cycles -> dig_sel cycles 1110,1101,1011,0111 every 4 clk; seg_out=1111111 (all blanked); frame_done pulses every 16 clk.
2. load with bcd_in=16'h1234, blank_in=0000 mid-frame -> load_ack one cycle later; old (blank) display persists until wrap; next frame digit0 shows 4 (seg_out=1001100), digit3 shows 1 (1001111).
3. Load 16'h00A7, then load 16'h5678 before the wrap -> two acks; committed frame shows 5678; the A nibble never appears.
4. load asserted exactly on the wrapping tick with 16'h9999 -> 9 (0000100) on digit0 in the very next slot; pending=0.
5. bcd_in=16'h000C, blank_in=0100 -> digit0 shows dash (1111110), digit2 dark, digits1/3 show 0 (0000001); with SEG7_LEADING_ZERO_BLANK_EN defined, digits1-3 are dark.
6. Assert rst mid-slot with pending=1 -> outputs go inactive the same cycle; after release, pending=0 and the display stays blank.
